store_unit: RTL

Store-side memory functional unit for the out-of-order core: accepts store operations from the reservation station, computes the effective address, aligns the data and holds each store in an in-order store queue. Address/data completion is broadcast to the CDB so the ROB can mark the store done. The store is written to the data-memory write port only after the ROB commits it, making it the write-side counterpart of the load unit's read port on the same 1024-word dmem. Uncommitted stores are discarded on pipeline flush.

---
 rtl/store_unit_pkg.sv | 20 ++
 rtl/store_data_align.sv | 30 +++
 rtl/store_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store unit: queue entry layout,
// funct3 store encodings and data-memory geometry.
package store_unit_pkg;

  localparam int DMEM_WORDS = 1024;
  localparam int DMEM_AW    = $clog2(DMEM_WORDS);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // ROB tags sit in a parallel array in store_unit since their width is a top parameter
  typedef struct packed {
    logic [DMEM_AW-1:0] waddr;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               committed;
  } sq_entry_t;

endpackage

// File: rtl/store_data_align.sv
// Byte/halfword lane alignment for stores: replicates the store data across
// lanes and builds the byte-enable mask from the low address bits.
module store_data_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  always_comb begin
    wdata = rs2;
    wstrb = 4'h0;
    case (funct3)
      F3_SB: begin
        wdata = {4{rs2[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_SH: begin
        wdata = {2{rs2[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW:   wstrb = 4'hF;
      default: wstrb = 4'h0; // unknown encodings complete but write no bytes
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// In-order store queue: enqueue from RS, CDB completion pulse, commit by ROB tag,
// drain committed head to the dmem write port. Define STORE_SUBWORD_EN for SB/SH.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ROB_TAG_W = 4,
  parameter int SQ_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 mem_write_i,
  input  logic [31:0]          rs1_val_i,
  input  logic [31:0]          rs2_val_i,
  input  logic [31:0]          imm_i,
  input  logic [2:0]           funct3_i,
  input  logic [ROB_TAG_W-1:0] rob_tag_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [ROB_TAG_W-1:0] rob_tag_o,
  input  logic                 commit_i,
  input  logic [ROB_TAG_W-1:0] commit_tag_i,
  input  logic                 flush_i,
  output logic                 mem_we_o,
  output logic [DMEM_AW-1:0]   mem_waddr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_wstrb_o
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = $clog2(SQ_DEPTH + 1);

  sq_entry_t            q     [SQ_DEPTH];
  logic [ROB_TAG_W-1:0] q_tag [SQ_DEPTH];
  logic [PTR_W-1:0]     head, cmt_ptr, tail;
  logic [CNT_W-1:0]     count, n_cmt, n_cmt_nxt;

  logic [31:0] addr, enq_wdata;
  logic [3:0]  enq_wstrb;
  logic        do_enq, do_commit, do_drain;
  logic        unused_bits;

  assign addr = rs1_val_i + imm_i;

`ifdef STORE_SUBWORD_EN
  store_data_align u_align (
    .addr_lo (addr[1:0]),
    .funct3  (funct3_i),
    .rs2     (rs2_val_i),
    .wdata   (enq_wdata),
    .wstrb   (enq_wstrb)
  );
  assign unused_bits = ^addr[31:DMEM_AW+2];
`else
  assign enq_wdata   = rs2_val_i;
  assign enq_wstrb   = 4'hF;
  assign unused_bits = ^{addr[31:DMEM_AW+2], addr[1:0], funct3_i};
`endif

  assign ready_o   = count < CNT_W'(SQ_DEPTH);
  assign do_enq    = valid_i && mem_write_i && ready_o && !flush_i;
  assign do_commit = commit_i && (count > n_cmt) && (q_tag[cmt_ptr] == commit_tag_i);
  assign do_drain  = (count != '0) && q[head].committed;
  assign n_cmt_nxt = n_cmt + CNT_W'(do_commit) - CNT_W'(do_drain);

  // Write port is driven straight from the head so a commit reaches dmem one cycle later
  assign mem_we_o    = do_drain;
  assign mem_waddr_o = do_drain ? q[head].waddr : '0;
  assign mem_wdata_o = do_drain ? q[head].wdata : '0;
  assign mem_wstrb_o = do_drain ? q[head].wstrb : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      cmt_ptr   <= '0;
      tail      <= '0;
      count     <= '0;
      n_cmt     <= '0;
      valid_o   <= 1'b0;
      rob_tag_o <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        q[i]     <= '0;
        q_tag[i] <= '0;
      end
    end else begin
      valid_o <= do_enq;
      if (do_enq) begin
        rob_tag_o <= rob_tag_i;
        q[tail]   <= '{waddr: addr[DMEM_AW+1:2], wdata: enq_wdata,
                       wstrb: enq_wstrb, committed: 1'b0};
        q_tag[tail] <= rob_tag_i;
      end
      if (do_commit) q[cmt_ptr].committed <= 1'b1;
      head    <= head + PTR_W'(do_drain);
      cmt_ptr <= cmt_ptr + PTR_W'(do_commit);
      n_cmt   <= n_cmt_nxt;
      // Flush keeps everything up to and including a same-cycle commit
      if (flush_i) begin
        tail  <= cmt_ptr + PTR_W'(do_commit);
        count <= n_cmt_nxt;
      end else begin
        tail  <= tail + PTR_W'(do_enq);
        count <= count + CNT_W'(do_enq) - CNT_W'(do_drain);
      end
    end
  end

endmodule
